// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: opcodes, FSM
// states and the iteration count of the 32-bit shift-add / restoring loop.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MTHI  = 2'b10,
    OP_MTLO  = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int ITERATIONS = 32;
  localparam int CNT_W      = 6;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

endpackage

// File: rtl/mult_div_unit.sv
// Iterative unsigned MULTU/DIVU unit with HI/LO registers and MTHI/MTLO moves.
// One bit per cycle through a shared 64-bit accumulator and 33-bit adder.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  // Shared adder: MULTU adds the multiplicand to the upper half, DIVU subtracts
  // the divisor from the left-shifted partial remainder (x + ~y + 1).
  logic               is_div;
  logic [WIDTH:0]     add_x;
  logic [WIDTH:0]     add_y;
  logic [WIDTH+1:0]   add_sum;
  logic               no_borrow;
  logic [WIDTH-1:0]   rem_next;
  logic [2*WIDTH-1:0] mul_step;
  logic [2*WIDTH-1:0] div_step;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    is_div  = (op_q == OP_DIVU);
    add_x   = is_div ? acc_q[2*WIDTH-1:WIDTH-1] : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    add_y   = is_div ? ~{1'b0, opnd_q} : {1'b0, opnd_q};
    add_sum = {1'b0, add_x} + {1'b0, add_y} + (WIDTH+2)'(is_div);

    // Multiplier bit in acc[0] selects add-or-pass; the shift drops it out.
    mul_step = acc_q[0] ? {add_sum[WIDTH:0], acc_q[WIDTH-1:1]}
                        : {1'b0, acc_q[2*WIDTH-1:1]};

    // Carry out of the subtract means remainder >= divisor: keep the difference.
    // A zero divisor never borrows, which yields quotient all-ones, remainder A.
    no_borrow = add_sum[WIDTH+1];
    rem_next  = no_borrow ? add_sum[WIDTH-1:0] : acc_q[2*WIDTH-2:WIDTH-1];
    div_step  = {rem_next, acc_q[WIDTH-2:0], no_borrow};

    acc_step  = is_div ? div_step : mul_step;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          unique case (op_e'(Op))
            OP_MULTU: begin
              state_d = ST_RUN;
              cnt_d   = '0;
              op_d    = OP_MULTU;
              opnd_d  = A;
              acc_d   = {{WIDTH{1'b0}}, B};
            end
            OP_DIVU: begin
              state_d = ST_RUN;
              cnt_d   = '0;
              op_d    = OP_DIVU;
              opnd_d  = B;
              acc_d   = {{WIDTH{1'b0}}, A};
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          hi_d    = acc_step[2*WIDTH-1:WIDTH];
          lo_d    = acc_step[WIDTH-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset along with the control flops because
  // HI/LO are architecturally visible and must read zero straight out of reset.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULTU;
      opnd_q  <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign Busy = (state_q == ST_RUN);
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// multi-cycle corner sequences and random operations against an arithmetic model.
module tb_mult_div_unit;

  logic        Clk;
  logic        Rst_n;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int checks = 0;
  int errors = 0;

  logic [31:0] cur_hi;
  logic [31:0] cur_lo;

  localparam logic [1:0] MULTU = 2'b00;
  localparam logic [1:0] DIVU  = 2'b01;
  localparam logic [1:0] MTHI  = 2'b10;
  localparam logic [1:0] MTLO  = 2'b11;

  mult_div_unit #(.WIDTH(32)) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .Start(Start),
    .Op   (Op),
    .A    (A),
    .B    (B),
    .Busy (Busy),
    .Done (Done),
    .Hi   (Hi),
    .Lo   (Lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic on the architected HI/LO pair.
  function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] hi, inout logic [31:0] lo);
    logic [63:0] prod;
    case (op)
      MULTU: begin
        prod = 64'(a) * 64'(b);
        hi   = prod[63:32];
        lo   = prod[31:0];
      end
      DIVU: begin
        if (b == 0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else begin
          hi = a % b;
          lo = a / b;
        end
      end
      MTHI:    hi = a;
      default: lo = a;
    endcase
  endfunction

  // Called at a falling edge: present the request for one rising edge, then
  // scramble the operands to show they were captured.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    Op    = op;
    A     = a;
    B     = b;
    @(negedge Clk);
    Start = 1'b0;
    Op    = 2'($urandom);
    A     = $urandom;
    B     = $urandom;
  endtask

  // Entered at cycle 1 after acceptance; returns at cycle 33 (Done cycle).
  task automatic check_run(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int bad = 0;
    for (int i = 1; i <= 32; i++) begin
      if (Busy !== 1'b1 || Done !== 1'b0 || Hi !== cur_hi || Lo !== cur_lo) bad++;
      if (i < 32) @(negedge Clk);
    end
    @(negedge Clk);
    check({name, " busy cycles 1-32 with HI/LO held"}, 64'(bad), 64'd0);
    check({name, " busy/done at cycle 33"}, {62'd0, Busy, Done}, 64'b01);
    check({name, " hi"}, 64'(Hi), 64'(exp_hi));
    check({name, " lo"}, 64'(Lo), 64'(exp_lo));
    cur_hi = exp_hi;
    cur_lo = exp_lo;
  endtask

  task automatic run_vec(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    issue(op, a, b);
    if (op == MTHI || op == MTLO) begin
      check({name, " busy/done stay low"}, {62'd0, Busy, Done}, 64'b00);
      check({name, " hi"}, 64'(Hi), 64'(exp_hi));
      check({name, " lo"}, 64'(Lo), 64'(exp_lo));
      cur_hi = exp_hi;
      cur_lo = exp_lo;
    end else begin
      check_run(name, exp_hi, exp_lo);
      @(negedge Clk);
      check({name, " done pulse ends"}, {62'd0, Busy, Done}, 64'b00);
      check({name, " hi/lo held in idle"}, {Hi, Lo}, {exp_hi, exp_lo});
    end
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] mh, ml, ra, rb;
    logic [1:0]  rop;
    int          done_seen;

    vecs.push_back('{"multu max",   MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{"divu 100/7",  DIVU,  32'd100,       32'd7,         32'd2,         32'd14});
    vecs.push_back('{"divu by 0",   DIVU,  32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF});
    vecs.push_back('{"mthi",        MTHI,  32'hCAFE_F00D, 32'h1111_1111, 32'hCAFE_F00D, 32'hFFFF_FFFF});
    vecs.push_back('{"mtlo",        MTLO,  32'h0000_BEEF, 32'h2222_2222, 32'hCAFE_F00D, 32'h0000_BEEF});
    vecs.push_back('{"multu zero",  MULTU, 32'd0,         32'h0001_2345, 32'd0,         32'd0});
    vecs.push_back('{"multu 2^32",  MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0});
    vecs.push_back('{"divu 5/9",    DIVU,  32'd5,         32'd9,         32'd5,         32'd0});
    vecs.push_back('{"divu max/1",  DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF});
    vecs.push_back('{"divu max/max",DIVU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1});

    Rst_n = 1'b0;
    Start = 1'b0;
    Op    = 2'b00;
    A     = '0;
    B     = '0;
    cur_hi = '0;
    cur_lo = '0;
    #3;
    check("reset outputs", {30'd0, Busy, Done, Hi}, 64'd0);
    check("reset lo", 64'(Lo), 64'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    foreach (vecs[i])
      run_vec(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);

    // Start (MTLO) arriving mid-run must be ignored.
    issue(MULTU, 32'd3, 32'd4);
    repeat (4) @(negedge Clk);
    issue(MTLO, 32'hDEAD_BEEF, 32'd0);
    check("ignored mtlo busy at cycle 6", {63'd0, Busy}, 64'd1);
    check("ignored mtlo lo untouched", 64'(Lo), 64'(cur_lo));
    repeat (27) @(negedge Clk);
    check("ignored mtlo done at cycle 33", {62'd0, Busy, Done}, 64'b01);
    check("ignored mtlo final hi/lo", {Hi, Lo}, {32'd0, 32'd12});
    cur_hi = 32'd0;
    cur_lo = 32'd12;
    @(negedge Clk);

    // Back-to-back: second request accepted in the Done cycle.
    issue(MULTU, 32'd2, 32'd3);
    check_run("b2b multu 2x3", 32'd0, 32'd6);
    issue(DIVU, 32'd9, 32'd2);
    check_run("b2b divu 9/2", 32'd1, 32'd4);
    @(negedge Clk);

    // Reset in cycle 10 of a divide, then a move on the first edge after release.
    issue(DIVU, 32'd1000, 32'd3);
    repeat (9) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    check("mid-run reset busy/done", {62'd0, Busy, Done}, 64'b00);
    check("mid-run reset hi/lo", {Hi, Lo}, 64'd0);
    cur_hi = '0;
    cur_lo = '0;
    @(negedge Clk);
    Rst_n = 1'b1;
    issue(MTHI, 32'd5, 32'd0);
    check("mthi after reset", {Hi, Lo}, {32'd5, 32'd0});
    cur_hi = 32'd5;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done !== 1'b0 || Busy !== 1'b0) done_seen++;
      @(negedge Clk);
    end
    check("no done after discarded divide", 64'(done_seen), 64'd0);

    // Random operations against the arithmetic model.
    for (int n = 0; n < 24; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      mh = cur_hi;
      ml = cur_lo;
      ref_op(rop, ra, rb, mh, ml);
      run_vec($sformatf("random #%0d op%0d a=%h b=%h", n, rop, ra, rb), rop, ra, rb, mh, ml);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/HI/LO width; only 32 is supported.
REQ-002 SHALL have port: Clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: Start  input  1  request strobe from execute stage; sampled each rising edge.
REQ-005 SHALL have port: Op  input  2  00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO.
REQ-006 SHALL have port: A  input  32  rs operand (dividend / multiplicand / move source).
REQ-007 SHALL have port: B  input  32  rt operand (divisor / multiplier).
REQ-008 SHALL have port: Busy  output  1  iterative operation in progress; pipeline stalls on it.
REQ-009 SHALL have port: Done  output  1  one-cycle pulse, Hi/Lo just updated by MULTU/DIVU.
REQ-010 SHALL have port: Hi  output  32  HI register.
REQ-011 SHALL have port: Lo  output  32  LO register.

Function
REQ-012 SHALL accept a request only in a cycle with Start=1 and Busy=0; Start while Busy=1 is ignored, no state change.
REQ-013 SHALL implement states IDLE, RUN, with IDLE->RUN on accepted MULTU/DIVU, and RUN->IDLE after 32 iterations.
REQ-014 SHALL capture A, B and Op into internal registers on acceptance; later A/B/Op changes have no effect.
REQ-015 SHALL, for Start accepted in cycle 0, drive Busy=1 in cycles 1-32, Busy=0 in cycle 33.
REQ-016 SHALL load Hi/Lo and assert Done=1 for exactly cycle 33; Hi/Lo are unchanged in cycles 1-32.
REQ-017 SHALL accept a new Start in cycle 33 (back-to-back, no bubble beyond Done cycle).
REQ-018 SHALL compute MULTU as an unsigned 32x32 shift-add, one multiplier bit per RUN cycle, with {Hi,Lo} = full 64-bit product.
REQ-019 SHALL compute DIVU as unsigned restoring division, one quotient bit per RUN cycle, with Lo = quotient and Hi = remainder.
REQ-020 SHALL, for DIVU with B=0, produce no exception and take the same 33-cycle latency, with Lo=0xFFFFFFFF and Hi=A.
REQ-021 SHALL, for MTHI/MTLO, write A into Hi/Lo at the accepting edge (visible cycle 1), leaving the other register unchanged.
REQ-022 SHALL keep Busy=0 and Done=0 for MTHI/MTLO.
REQ-023 SHALL use a 6-bit iteration counter, loaded 0 on acceptance, incremented each RUN cycle, with completion at count 31.
REQ-024 SHALL hold Hi/Lo indefinitely in IDLE.
REQ-025 SHALL drive outputs only from registers (no combinational input-to-output path).

Reset
REQ-026 SHALL, on Rst_n=0 at any time including mid-RUN, asynchronously force state IDLE, Busy=0, Done=0, Hi=0, Lo=0, counter=0.
REQ-027 SHALL discard any in-flight operation on reset, with no Done pulse afterwards.
REQ-028 SHALL accept Start on the first rising edge with Rst_n=1.

Structure
REQ-029 SHALL place Op encodings (OP_MULTU, OP_DIVU, OP_MTHI, OP_MTLO), state encoding and ITERATIONS=32 in shared package mdu_pkg.
REQ-030 SHALL be a single module with no sub-module; the multiply and divide paths share one 64-bit accumulator/remainder register and one 33-bit adder/subtractor.

Verification
REQ-031 SHALL cover MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Busy cycles 1-32, Done cycle 33, Hi=0xFFFFFFFE, Lo=0x00000001.
REQ-032 SHALL cover DIVU A=100, B=7 -> cycle 33 Lo=14, Hi=2; then DIVU A=0x12345678, B=0 -> Lo=0xFFFFFFFF, Hi=0x12345678.
REQ-033 SHALL cover a Start with MTLO A=0xDEADBEEF issued in cycle 5 of a MULTU 3x4 -> ignored; final Hi=0, Lo=12.
REQ-034 SHALL cover back-to-back MULTU 2x3 in cycle 0 then DIVU 9/2 in cycle 33 -> Lo=6 at cycle 33, Lo=4 and Hi=1 at cycle 66.
REQ-035 SHALL cover Rst_n=0 in cycle 10 of DIVU -> Hi=Lo=0, Busy=0 immediately, no Done; MTHI A=5 afterwards -> Hi=5, Lo=0.
